// File: rtl/mem_access_ctrl_if.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl_if
// Data-memory bus between the MEM-stage access controller and the memory.
//   req    master->slave  access request, held until ack
//   we     master->slave  1 store, 0 load
//   sel    master->slave  byte lanes, bit3 = address offset 0 (big-endian)
//   addr   master->slave  word address {addr[31:2],2'b00}
//   wdata  master->slave  lane-replicated store data
//   ack    slave->master  one-cycle completion pulse
//   rdata  slave->master  read data, valid with ack
// ---------------------------------------------------------------------------
interface mem_access_ctrl_if;
    logic        req;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;

    modport master (
        output req, we, sel, addr, wdata,
        input  ack, rdata
    );

    modport slave (
        input  req, we, sel, addr, wdata,
        output ack, rdata
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl
// MEM-stage load/store sequencer. Non-memory instructions pass wd/wreg/wdata
// straight through; loads and stores are run over a req/ack bus while the
// pipeline is held with stall_req_o. Handles big-endian byte-lane selection,
// store-data replication, load sign/zero extension and alignment checking.
//
// Optional build macro: MEM_CTRL_TIMEOUT_EN
//   defined   -> a request with no ack for TIMEOUT_CYCLES cycles is aborted
//                and reported on bus_err_o
//   undefined -> requests wait indefinitely, bus_err_o is tied 0
//
// Ports
//   clk          clock, all state on rising edge
//   rst          synchronous active-high reset; all outputs 0 while high
//   mem_op_i     0 NONE,1 LB,2 LBU,3 LH,4 LHU,5 LW,6 SB,7 SH,8 SW (9-15 NONE)
//   mem_addr_i   effective address
//   mem_wdata_i  store data (rt)
//   wd_i/wreg_i/wdata_i   destination, write enable, ALU result
//   bus          mem_access_ctrl_if master modport
//   stall_req_o  hold IF..MEM this cycle
//   wd_o/wreg_o/wdata_o   to MEM/WB
//   misalign_o   misaligned access flagged this cycle
//   bus_err_o    access aborted by timeout
//
// state | meaning
// IDLE  | pass-through; start an aligned access, flag a misaligned one
// REQ   | bus_req held with latched address/lanes/data until ack
// DONE  | deliver captured load data (or error) to MEM/WB, release stall
// ---------------------------------------------------------------------------
module mem_access_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [3:0]                mem_op_i,
    input  logic [31:0]               mem_addr_i,
    input  logic [31:0]               mem_wdata_i,
    input  logic [4:0]                wd_i,
    input  logic                      wreg_i,
    input  logic [31:0]               wdata_i,
    mem_access_ctrl_if.master         bus,
    output logic                      stall_req_o,
    output logic [4:0]                wd_o,
    output logic                      wreg_o,
    output logic [31:0]               wdata_o,
    output logic                      misalign_o,
    output logic                      bus_err_o
);

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LBU = 4'd2;
    localparam logic [3:0] OP_LH  = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_LW  = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  op_q,    op_d;
    logic [31:0] addr_q,  addr_d;
    logic [1:0]  off_q,   off_d;
    logic [3:0]  sel_q,   sel_d;
    logic        we_q,    we_d;
    logic [31:0] bwd_q,   bwd_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q,   err_d;

    // ------------------------------------------------------------------
    // Instruction decode for the op currently presented by EX/MEM
    // ------------------------------------------------------------------
    logic        is_access_c;
    logic        is_store_c;
    logic        misalign_c;
    logic [3:0]  sel_c;
    logic [31:0] bwd_c;

    always_comb begin
        is_access_c = 1'b0;
        is_store_c  = 1'b0;
        misalign_c  = 1'b0;
        sel_c       = 4'b0000;
        bwd_c       = 32'h0;
        case (mem_op_i)
            OP_LB, OP_LBU, OP_SB: begin
                is_access_c = 1'b1;
                is_store_c  = (mem_op_i == OP_SB);
                sel_c       = 4'b1000 >> mem_addr_i[1:0];
                bwd_c       = {4{mem_wdata_i[7:0]}};
            end
            OP_LH, OP_LHU, OP_SH: begin
                is_access_c = 1'b1;
                is_store_c  = (mem_op_i == OP_SH);
                misalign_c  = mem_addr_i[0];
                sel_c       = mem_addr_i[1] ? 4'b0011 : 4'b1100;
                bwd_c       = {2{mem_wdata_i[15:0]}};
            end
            OP_LW, OP_SW: begin
                is_access_c = 1'b1;
                is_store_c  = (mem_op_i == OP_SW);
                misalign_c  = (mem_addr_i[1:0] != 2'b00);
                sel_c       = 4'b1111;
                bwd_c       = mem_wdata_i;
            end
            default: ;
        endcase
    end

    // Big-endian: offset 0 is the most significant byte of the bus word.
    function automatic logic [31:0] load_ext(input logic [3:0]  op,
                                             input logic [1:0]  off,
                                             input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = d[31:24];
            2'd1:    b = d[23:16];
            2'd2:    b = d[15:8];
            default: b = d[7:0];
        endcase
        h = off[1] ? d[15:0] : d[31:16];
        case (op)
            OP_LB:   load_ext = {{24{b[7]}}, b};
            OP_LBU:  load_ext = {24'h0, b};
            OP_LH:   load_ext = {{16{h[15]}}, h};
            OP_LHU:  load_ext = {16'h0, h};
            default: load_ext = d;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Request timeout
    // ------------------------------------------------------------------
`ifdef MEM_CTRL_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tmo_hit_c;
    // cnt_q counts completed ack-less REQ cycles; the limit is reached on the
    // edge that ends the TIMEOUT_CYCLES-th one.
    assign tmo_hit_c = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic unused_cfg;
    assign unused_cfg = (TIMEOUT_CYCLES == 0);
`endif

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        off_d   = off_q;
        sel_d   = sel_q;
        we_d    = we_q;
        bwd_d   = bwd_q;
        rdata_d = rdata_q;
        err_d   = err_q;
`ifdef MEM_CTRL_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (is_access_c && !misalign_c) begin
                    state_d = S_REQ;
                    op_d    = mem_op_i;
                    addr_d  = {mem_addr_i[31:2], 2'b00};
                    off_d   = mem_addr_i[1:0];
                    sel_d   = sel_c;
                    we_d    = is_store_c;
                    bwd_d   = is_store_c ? bwd_c : 32'h0;
                    rdata_d = 32'h0;
                    err_d   = 1'b0;
`ifdef MEM_CTRL_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            S_REQ: begin
                if (bus.ack) begin
                    state_d = S_DONE;
                    rdata_d = we_q ? 32'h0 : load_ext(op_q, off_q, bus.rdata);
                end
`ifdef MEM_CTRL_TIMEOUT_EN
                else if (tmo_hit_c) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                end
`endif
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= 4'h0;
            addr_q  <= 32'h0;
            off_q   <= 2'b00;
            sel_q   <= 4'h0;
            we_q    <= 1'b0;
            bwd_q   <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
`ifdef MEM_CTRL_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            off_q   <= off_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            bwd_q   <= bwd_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
`ifdef MEM_CTRL_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Outputs. Everything is forced to 0 while rst is high, including the
    // pass-through and bus signals that would otherwise follow state_q.
    // ------------------------------------------------------------------
    always_comb begin
        bus.req     = 1'b0;
        bus.we      = 1'b0;
        bus.sel     = 4'h0;
        bus.addr    = 32'h0;
        bus.wdata   = 32'h0;
        stall_req_o = 1'b0;
        wd_o        = 5'h0;
        wreg_o      = 1'b0;
        wdata_o     = 32'h0;
        misalign_o  = 1'b0;
        bus_err_o   = 1'b0;
        if (!rst) begin
            case (state_q)
                S_IDLE: begin
                    wd_o    = wd_i;
                    wreg_o  = wreg_i;
                    wdata_o = wdata_i;
                    if (is_access_c) begin
                        // No write-back until the access has delivered data.
                        wreg_o = 1'b0;
                        if (misalign_c) begin
                            misalign_o = 1'b1;
                        end else begin
                            stall_req_o = 1'b1;
                        end
                    end
                end
                S_REQ: begin
                    bus.req     = 1'b1;
                    bus.we      = we_q;
                    bus.sel     = sel_q;
                    bus.addr    = addr_q;
                    bus.wdata   = bwd_q;
                    stall_req_o = 1'b1;
                    wd_o        = wd_i;
                end
                S_DONE: begin
                    wd_o      = wd_i;
                    wreg_o    = wreg_i && !we_q && !err_q;
                    wdata_o   = rdata_q;
                    bus_err_o = err_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  mem_op_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_wdata_i;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic [31:0] wdata_i;
    logic        stall_req_o;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic        misalign_o;
    logic        bus_err_o;

    int errors = 0;
    int checks = 0;

    mem_access_ctrl_if bus_if ();

    mem_access_ctrl #(.TIMEOUT_CYCLES(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_op_i    (mem_op_i),
        .mem_addr_i  (mem_addr_i),
        .mem_wdata_i (mem_wdata_i),
        .wd_i        (wd_i),
        .wreg_i      (wreg_i),
        .wdata_i     (wdata_i),
        .bus         (bus_if.master),
        .stall_req_o (stall_req_o),
        .wd_o        (wd_o),
        .wreg_o      (wreg_o),
        .wdata_o     (wdata_o),
        .misalign_o  (misalign_o),
        .bus_err_o   (bus_err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] mwd,
                         input logic [4:0] wd, input logic wreg, input logic [31:0] wdat);
        mem_op_i    = op;
        mem_addr_i  = addr;
        mem_wdata_i = mwd;
        wd_i        = wd;
        wreg_i      = wreg;
        wdata_i     = wdat;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Full access: IDLE cycle, waits+1 REQ cycles (ack in last), DONE cycle.
    task automatic run_access(input string name, input logic [3:0] op, input logic [31:0] addr,
                              input logic [31:0] mwd, input logic [4:0] wd, input int waits,
                              input logic [31:0] rdata, input logic [3:0] e_sel, input logic e_we,
                              input logic [31:0] e_bwd, input logic e_wreg, input logic [31:0] e_wdata);
        int stalls;
        stalls = 0;
        drive(op, addr, mwd, wd, 1'b1, 32'h5A5A_5A5A);
        @(negedge clk);
        chk({name, " idle_req"}, {31'h0, bus_if.req}, 32'h0);
        if (stall_req_o) stalls++;
        for (int i = 0; i <= waits; i++) begin
            next_cycle();
            bus_if.ack   = (i == waits);
            bus_if.rdata = (i == waits) ? rdata : 32'hDEAD_0000;
            @(negedge clk);
            if (stall_req_o) stalls++;
            if (i == 0) begin
                chk({name, " req"},   {31'h0, bus_if.req}, 32'h1);
                chk({name, " sel"},   {28'h0, bus_if.sel}, {28'h0, e_sel});
                chk({name, " we"},    {31'h0, bus_if.we},  {31'h0, e_we});
                chk({name, " addr"},  bus_if.addr, {addr[31:2], 2'b00});
                if (e_we) chk({name, " bus_wdata"}, bus_if.wdata, e_bwd);
            end
        end
        next_cycle();
        bus_if.ack = 1'b0;
        @(negedge clk);
        chk({name, " stall_cycles"}, stalls, waits + 2);
        chk({name, " done_stall"}, {31'h0, stall_req_o}, 32'h0);
        chk({name, " done_req"},   {31'h0, bus_if.req}, 32'h0);
        chk({name, " done_wreg"},  {31'h0, wreg_o}, {31'h0, e_wreg});
        chk({name, " done_wd"},    {27'h0, wd_o}, {27'h0, wd});
        chk({name, " done_err"},   {31'h0, bus_err_o}, 32'h0);
        if (!e_we) chk({name, " done_wdata"}, wdata_o, e_wdata);
        next_cycle();
        drive(4'd0, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
    endtask

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] addr;
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic        e_mis;
        logic        e_wreg;
        logic        chk_data;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{"none",     4'd0,  32'h0000_0000, 5'd5,  1'b1, 32'h0000_1234, 1'b0, 1'b1, 1'b1};
        vecs[1] = '{"op12",     4'd12, 32'h0000_0103, 5'd31, 1'b1, 32'hCAFE_F00D, 1'b0, 1'b1, 1'b1};
        vecs[2] = '{"none_nw",  4'd0,  32'h0000_0000, 5'd7,  1'b0, 32'h8765_4321, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{"lw_mis",   4'd5,  32'h0000_0103, 5'd3,  1'b1, 32'h0,         1'b1, 1'b0, 1'b0};
        vecs[4] = '{"lh_mis",   4'd3,  32'h0000_0101, 5'd3,  1'b1, 32'h0,         1'b1, 1'b0, 1'b0};
        vecs[5] = '{"sw_mis",   4'd8,  32'h0000_0102, 5'd3,  1'b0, 32'h0,         1'b1, 1'b0, 1'b0};
        vecs[6] = '{"lhu_mis",  4'd4,  32'h0000_00FF, 5'd3,  1'b1, 32'h0,         1'b1, 1'b0, 1'b0};
        vecs[7] = '{"sh_mis",   4'd7,  32'h0000_0203, 5'd3,  1'b0, 32'h0,         1'b1, 1'b0, 1'b0};

        bus_if.ack   = 1'b0;
        bus_if.rdata = 32'h0;
        rst = 1'b1;
        drive(4'd5, 32'h0000_0100, 32'h1111_2222, 5'd5, 1'b1, 32'h0000_1234);
        @(negedge clk);
        chk("rst_stall", {31'h0, stall_req_o}, 32'h0);
        chk("rst_wreg",  {31'h0, wreg_o}, 32'h0);
        chk("rst_wd",    {27'h0, wd_o}, 32'h0);
        chk("rst_wdata", wdata_o, 32'h0);
        chk("rst_req",   {31'h0, bus_if.req}, 32'h0);
        next_cycle();
        rst = 1'b0;
        drive(4'd0, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
        next_cycle();

        // Single-cycle IDLE behaviour: pass-through and misalignment.
        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].op, vecs[i].addr, 32'hFFFF_FFFF, vecs[i].wd, vecs[i].wreg, vecs[i].wdata);
            @(negedge clk);
            chk({vecs[i].name, " stall"},    {31'h0, stall_req_o}, 32'h0);
            chk({vecs[i].name, " req"},      {31'h0, bus_if.req}, 32'h0);
            chk({vecs[i].name, " misalign"}, {31'h0, misalign_o}, {31'h0, vecs[i].e_mis});
            chk({vecs[i].name, " wreg"},     {31'h0, wreg_o}, {31'h0, vecs[i].e_wreg});
            if (vecs[i].chk_data) begin
                chk({vecs[i].name, " wd"},    {27'h0, wd_o}, {27'h0, vecs[i].wd});
                chk({vecs[i].name, " wdata"}, wdata_o, vecs[i].wdata);
            end
            next_cycle();
        end
        drive(4'd0, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
        @(negedge clk);
        chk("after_mis req", {31'h0, bus_if.req}, 32'h0);
        next_cycle();

        // Ack while idle is ignored.
        bus_if.ack = 1'b1;
        bus_if.rdata = 32'hFFFF_FFFF;
        drive(4'd0, 32'h0, 32'h0, 5'd9, 1'b1, 32'h0000_00AA);
        next_cycle();
        bus_if.ack = 1'b0;
        @(negedge clk);
        chk("idle_ack stall", {31'h0, stall_req_o}, 32'h0);
        chk("idle_ack wdata", wdata_o, 32'h0000_00AA);
        chk("idle_ack req",   {31'h0, bus_if.req}, 32'h0);
        next_cycle();

        run_access("lb",  4'd1, 32'h0000_0101, 32'h0,         5'd4,  2, 32'h00F0_0000, 4'b0100, 1'b0, 32'h0,         1'b1, 32'hFFFF_FFF0);
        run_access("lbu", 4'd2, 32'h0000_0103, 32'h0,         5'd6,  0, 32'h1234_5685, 4'b0001, 1'b0, 32'h0,         1'b1, 32'h0000_0085);
        run_access("lh",  4'd3, 32'h0000_0100, 32'h0,         5'd8,  1, 32'h8001_7777, 4'b1100, 1'b0, 32'h0,         1'b1, 32'hFFFF_8001);
        run_access("lhu", 4'd4, 32'h0000_0102, 32'h0,         5'd9,  0, 32'h1234_9ABC, 4'b0011, 1'b0, 32'h0,         1'b1, 32'h0000_9ABC);
        run_access("lw",  4'd5, 32'h0000_0200, 32'h0,         5'd10, 1, 32'hDEAD_BEEF, 4'b1111, 1'b0, 32'h0,         1'b1, 32'hDEAD_BEEF);
        run_access("sh",  4'd7, 32'h0000_0202, 32'hAABB_CCDD, 5'd11, 0, 32'h0,         4'b0011, 1'b1, 32'hCCDD_CCDD, 1'b0, 32'h0);
        run_access("sb",  4'd6, 32'h0000_0301, 32'h1122_3344, 5'd12, 1, 32'h0,         4'b0100, 1'b1, 32'h4444_4444, 1'b0, 32'h0);
        run_access("sw",  4'd8, 32'h0000_0304, 32'h1122_3344, 5'd13, 0, 32'h0,         4'b1111, 1'b1, 32'h1122_3344, 1'b0, 32'h0);
        // Ack lands on the same edge a 4-cycle timeout would fire: normal completion.
        run_access("lw_edge", 4'd5, 32'h0000_0404, 32'h0,     5'd14, 3, 32'h0BAD_F00D, 4'b1111, 1'b0, 32'h0,         1'b1, 32'h0BAD_F00D);

        // Reset while in REQ; late ack must be dropped.
        drive(4'd5, 32'h0000_0400, 32'h0, 5'd2, 1'b1, 32'h0);
        next_cycle();
        @(negedge clk);
        chk("rstreq in_req", {31'h0, bus_if.req}, 32'h1);
        next_cycle();
        rst = 1'b1;
        drive(4'd0, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
        @(negedge clk);
        chk("rstreq req_during", {31'h0, bus_if.req}, 32'h0);
        chk("rstreq stall_during", {31'h0, stall_req_o}, 32'h0);
        next_cycle();
        rst = 1'b0;
        bus_if.ack = 1'b1;
        bus_if.rdata = 32'h1234_5678;
        @(negedge clk);
        chk("rstreq req_after",  {31'h0, bus_if.req}, 32'h0);
        chk("rstreq stall_after", {31'h0, stall_req_o}, 32'h0);
        chk("rstreq wdata_after", wdata_o, 32'h0);
        chk("rstreq wreg_after",  {31'h0, wreg_o}, 32'h0);
        next_cycle();
        bus_if.ack = 1'b0;
        @(negedge clk);
        chk("rstreq late_ack wdata", wdata_o, 32'h0);
        chk("rstreq late_ack stall", {31'h0, stall_req_o}, 32'h0);
        next_cycle();

`ifdef MEM_CTRL_TIMEOUT_EN
        begin
            int reqs;
            reqs = 0;
            drive(4'd5, 32'h0000_0500, 32'h0, 5'd3, 1'b1, 32'h0);
            next_cycle();
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                if (bus_if.req) reqs++;
                next_cycle();
            end
            @(negedge clk);
            chk("tmo req_cycles", reqs, 4);
            chk("tmo req_dropped", {31'h0, bus_if.req}, 32'h0);
            chk("tmo bus_err", {31'h0, bus_err_o}, 32'h1);
            chk("tmo wreg", {31'h0, wreg_o}, 32'h0);
            chk("tmo stall", {31'h0, stall_req_o}, 32'h0);
            next_cycle();
            drive(4'd0, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
            @(negedge clk);
            chk("tmo err_clear", {31'h0, bus_err_o}, 32'h0);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
